life_ctrl: RTL

Generation sequencer and cursor controller for the Game of Life cell array. Drives the array's rotate enable (`nxt_bit`) so that each generation is exactly one full X*Y-cycle rotation. Supports run, pause and single-step modes with a programmable inter-generation delay. Owns the edit cursor (`cursor_x`/`cursor_y`) that the array uses for cell flips.

---
 rtl/life_pkg.sv | 26 ++
 rtl/life_key_edge.sv | 23 ++
 rtl/life_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared FSM state encodings and default geometry for the life controller.
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    localparam int DEF_X     = 8;
    localparam int DEF_Y     = 8;
    localparam int DEF_LOG2X = 3;
    localparam int DEF_LOG2Y = 3;
    localparam int DEF_CNT_W = 7;
    localparam int DEF_PER_W = 24;
    localparam int DEF_GEN_W = 16;

    // Bit positions of the keys inside the edge-detector vector.
    localparam int K_RUN   = 5;
    localparam int K_STEP  = 4;
    localparam int K_LEFT  = 3;
    localparam int K_RIGHT = 2;
    localparam int K_UP    = 1;
    localparam int K_DOWN  = 0;

endpackage

// File: rtl/life_key_edge.sv
// life_key_edge: W-bit rising-edge detector with async active-high reset.
//   clk, rst : clock, asynchronous active-high reset
//   key      : level inputs
//   rise     : key & ~previous key, one cycle per rising edge
module life_key_edge #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= key;
    end

    assign rise = key & ~prev;

endmodule

// File: rtl/life_ctrl.sv
// life_ctrl: Game of Life generation sequencer (run/pause/step, delay) and edit cursor.
//   clk, rst                     : clock, asynchronous active-high reset
//   key_run, key_step            : rising edge toggles run / starts one generation when paused
//   key_left/right/up/down       : rising edge moves the cursor with wraparound
//   period                       : idle cycles between generations while running (0 acts as 1)
//   nxt_bit                      : rotate enable, high X*Y cycles per generation
//   cursor_x, cursor_y           : cursor position
//   running                      : run flag
//   gen_done                     : pulse on the last rotate cycle of a generation
//   gen_count                    : completed generations, wraps
module life_ctrl
    import life_pkg::*;
#(
    parameter int X     = DEF_X,
    parameter int Y     = DEF_Y,
    parameter int LOG2X = DEF_LOG2X,
    parameter int LOG2Y = DEF_LOG2Y,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PER_W = DEF_PER_W,
    parameter int GEN_W = DEF_GEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_run,
    input  logic             key_step,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_up,
    input  logic             key_down,
    input  logic [PER_W-1:0] period,
    output logic             nxt_bit,
    output logic [LOG2X-1:0] cursor_x,
    output logic [LOG2Y-1:0] cursor_y,
    output logic             running,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(X * Y - 1);
    localparam logic [LOG2X-1:0] XMAX = LOG2X'(X - 1);
    localparam logic [LOG2Y-1:0] YMAX = LOG2Y'(Y - 1);

    state_t           state;
    logic [PER_W-1:0] timer;
    logic [PER_W-1:0] lim;
    logic [CNT_W-1:0] rc;
    logic [5:0]       ev;
    logic             run_e, step_e, left_e, right_e, up_e, down_e;
    logic             run_nxt;
    logic [LOG2X-1:0] x_nxt;
    logic [LOG2Y-1:0] y_nxt;

    life_key_edge #(.W(6)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .key  ({key_run, key_step, key_left, key_right, key_up, key_down}),
        .rise (ev)
    );

    assign run_e   = ev[K_RUN];
    assign step_e  = ev[K_STEP];
    assign left_e  = ev[K_LEFT];
    assign right_e = ev[K_RIGHT];
    assign up_e    = ev[K_UP];
    assign down_e  = ev[K_DOWN];

    // A zero period behaves as one idle cycle so the timer compare is always reachable.
    assign lim      = (period == '0) ? PER_W'(1) : period;
    // Run flag as it will be after this cycle; decides where a finishing sweep goes.
    assign run_nxt  = running ^ run_e;
    assign gen_done = (state == ST_SWEEP) && (rc == LAST);

    // Explicit wrap compares: X and Y need not be powers of two. Opposing edges cancel.
    always_comb begin
        x_nxt = (left_e && !right_e) ? ((cursor_x == '0) ? XMAX : cursor_x - 1'b1) :
                (right_e && !left_e) ? ((cursor_x == XMAX) ? '0 : cursor_x + 1'b1) :
                cursor_x;
        y_nxt = (up_e && !down_e) ? ((cursor_y == '0) ? YMAX : cursor_y - 1'b1) :
                (down_e && !up_e) ? ((cursor_y == YMAX) ? '0 : cursor_y + 1'b1) :
                cursor_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            cursor_x <= x_nxt;
            cursor_y <= y_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            rc        <= '0;
            nxt_bit   <= 1'b0;
            running   <= 1'b0;
            gen_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run_e) begin
                        state   <= ST_WAIT;
                        running <= 1'b1;
                        timer   <= '0;
                    end else if (step_e) begin
                        state   <= ST_SWEEP;
                        nxt_bit <= 1'b1;
                        rc      <= '0;
                    end
                end
                ST_WAIT: begin
                    if (run_e) begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end else if (timer == lim - 1'b1) begin
                        state   <= ST_SWEEP;
                        nxt_bit <= 1'b1;
                        rc      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SWEEP: begin
                    // Sweeps always complete; a run edge here only flips the flag.
                    running <= run_nxt;
                    if (rc == LAST) begin
                        rc        <= '0;
                        nxt_bit   <= 1'b0;
                        gen_count <= gen_count + 1'b1;
                        timer     <= '0;
                        state     <= run_nxt ? ST_WAIT : ST_IDLE;
                    end else begin
                        rc <= rc + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    nxt_bit <= 1'b0;
                end
            endcase
        end
    end

endmodule
